// File: rtl/ttc3_secret_vault.sv
// Multi-slot write-once secret vault between the provisioning path and the KDF.
// Optional per-slot read limit enabled by defining TTC3_VAULT_READ_LIMIT_EN.
module ttc3_secret_vault #(
    parameter int NUM_SLOTS    = 4,
    parameter int SECRET_WIDTH = 256,
    parameter int CHUNK_WIDTH  = 32,
`ifdef TTC3_VAULT_READ_LIMIT_EN
    parameter int READ_LIMIT   = 1,
`endif
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [SLOT_W-1:0]       wr_slot,
    input  logic [CHUNK_WIDTH-1:0]  wr_data,
    output logic                    wr_err,
    input  logic                    kdf_req,
    input  logic [SLOT_W-1:0]       kdf_slot,
    output logic                    kdf_ack,
    output logic [SECRET_WIDTH-1:0] kdf_data,
    output logic                    kdf_err,
    input  logic                    zeroize,
    output logic                    busy,
`ifdef TTC3_VAULT_READ_LIMIT_EN
    output logic [NUM_SLOTS-1:0]    reads_exhausted,
`endif
    output logic [NUM_SLOTS-1:0]    slot_valid
);

    localparam int NUM_CHUNKS = SECRET_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ZERO = 2'd2
    } state_t;

    state_t                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [SLOT_W-1:0]       load_slot_r;
    logic [SLOT_W-1:0]       zidx_r;
    logic [SECRET_WIDTH-1:0] secret_r [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]    slot_valid_r;
    logic                    wr_err_r;
    logic                    kdf_ack_r;
    logic                    kdf_err_r;
    logic [SECRET_WIDTH-1:0] kdf_data_r;
    logic                    busy_r;
    logic                    ready_en_r;

    logic wr_ready_s;
    logic wr_fire_s;
    logic wr_slot_ok_s;
    logic kdf_take_s;
    logic kdf_ok_s;

`ifdef TTC3_VAULT_READ_LIMIT_EN
    localparam int RC_W = (READ_LIMIT > 0) ? $clog2(READ_LIMIT + 1) : 1;
    logic [RC_W-1:0]      rcnt_r [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] exhausted_s;

    // A slot is exhausted once its read count has reached the limit.
    always_comb begin
        exhausted_s = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            exhausted_s[k] = (rcnt_r[k] >= RC_W'(READ_LIMIT));
        end
    end

    // Per-slot read counters: bumped on each ack, cleared as zeroize reaches the slot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                rcnt_r[k] <= '0;
            end
        end else if (kdf_take_s && kdf_ok_s) begin
            rcnt_r[kdf_slot] <= rcnt_r[kdf_slot] + RC_W'(1);
        end else if ((state_r == ST_ZERO) && !zeroize) begin
            rcnt_r[zidx_r] <= '0;
        end
    end

    assign reads_exhausted = exhausted_s;
`endif

    // ready_en_r keeps wr_ready low while reset is applied and for the release cycle.
    assign wr_ready_s = ready_en_r && (state_r != ST_ZERO) && !zeroize;
    assign wr_fire_s  = wr_valid && wr_ready_s;
    assign kdf_take_s = kdf_req && (state_r == ST_IDLE) && !zeroize && !wr_fire_s
                        && !kdf_ack_r && !kdf_err_r;

    // Write-once lock and range check for the first beat of a load.
    always_comb begin
        wr_slot_ok_s = 1'b0;
        if (int'(wr_slot) < NUM_SLOTS) begin
            wr_slot_ok_s = !slot_valid_r[wr_slot];
        end else begin
            wr_slot_ok_s = 1'b0;
        end
    end

    // A KDF read succeeds only for an in-range, loaded (and not exhausted) slot.
    always_comb begin
        kdf_ok_s = 1'b0;
        if (int'(kdf_slot) < NUM_SLOTS) begin
`ifdef TTC3_VAULT_READ_LIMIT_EN
            kdf_ok_s = slot_valid_r[kdf_slot] && !exhausted_s[kdf_slot];
`else
            kdf_ok_s = slot_valid_r[kdf_slot];
`endif
        end else begin
            kdf_ok_s = 1'b0;
        end
    end

    // Main FSM: zeroize beats write, write beats KDF; response pulses last one cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            load_slot_r  <= '0;
            zidx_r       <= '0;
            slot_valid_r <= '0;
            wr_err_r     <= 1'b0;
            kdf_ack_r    <= 1'b0;
            kdf_err_r    <= 1'b0;
            kdf_data_r   <= '0;
            busy_r       <= 1'b0;
            ready_en_r   <= 1'b0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                secret_r[k] <= '0;
            end
        end else begin
            ready_en_r <= 1'b1;
            wr_err_r   <= 1'b0;
            kdf_ack_r  <= 1'b0;
            kdf_err_r  <= 1'b0;
            kdf_data_r <= '0;
            if (zeroize) begin
                // Partial load chunks live in slot storage and are wiped by the sweep.
                state_r <= ST_ZERO;
                zidx_r  <= '0;
                cnt_r   <= '0;
                busy_r  <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (wr_fire_s) begin
                            if (!wr_slot_ok_s) begin
                                wr_err_r <= 1'b1;
                            end else begin
                                load_slot_r <= wr_slot;
                                secret_r[wr_slot][CHUNK_WIDTH-1:0] <= wr_data;
                                if (NUM_CHUNKS == 1) begin
                                    slot_valid_r[wr_slot] <= 1'b1;
                                end else begin
                                    cnt_r   <= CNT_W'(1);
                                    state_r <= ST_LOAD;
                                    busy_r  <= 1'b1;
                                end
                            end
                        end else if (kdf_take_s) begin
                            if (kdf_ok_s) begin
                                kdf_ack_r  <= 1'b1;
                                kdf_data_r <= secret_r[kdf_slot];
                            end else begin
                                kdf_err_r <= 1'b1;
                            end
                        end
                    end
                    ST_LOAD: begin
                        if (wr_fire_s) begin
                            secret_r[load_slot_r][int'(cnt_r)*CHUNK_WIDTH +: CHUNK_WIDTH] <= wr_data;
                            if (cnt_r == CNT_W'(NUM_CHUNKS - 1)) begin
                                slot_valid_r[load_slot_r] <= 1'b1;
                                cnt_r   <= '0;
                                state_r <= ST_IDLE;
                                busy_r  <= 1'b0;
                            end else begin
                                cnt_r <= cnt_r + CNT_W'(1);
                            end
                        end
                    end
                    ST_ZERO: begin
                        secret_r[zidx_r]     <= '0;
                        slot_valid_r[zidx_r] <= 1'b0;
                        if (zidx_r == SLOT_W'(NUM_SLOTS - 1)) begin
                            zidx_r  <= '0;
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            zidx_r <= zidx_r + SLOT_W'(1);
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign wr_ready   = wr_ready_s;
    assign wr_err     = wr_err_r;
    assign kdf_ack    = kdf_ack_r;
    assign kdf_err    = kdf_err_r;
    assign kdf_data   = kdf_data_r;
    assign busy       = busy_r;
    assign slot_valid = slot_valid_r;

endmodule

// File: tb/tb_ttc3_secret_vault.sv
// Scoreboard bench for ttc3_secret_vault: a 4-slot/256-bit vault and a 3-slot/32-bit
// vault (out-of-range slot index and single-beat commit).
module tb_ttc3_secret_vault;

`ifdef TTC3_VAULT_READ_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic [1:0]   wr_slot = 2'd0;
    logic [31:0]  wr_data = 32'd0;
    logic         wr_err;
    logic         kdf_req = 1'b0;
    logic [1:0]   kdf_slot = 2'd0;
    logic         kdf_ack;
    logic [255:0] kdf_data;
    logic         kdf_err;
    logic         zeroize = 1'b0;
    logic         busy;
    logic [3:0]   slot_valid;
    logic [3:0]   reads_exhausted;

    logic         t3_wr_valid = 1'b0;
    logic         t3_wr_ready;
    logic [1:0]   t3_wr_slot = 2'd0;
    logic [31:0]  t3_wr_data = 32'd0;
    logic         t3_wr_err;
    logic         t3_kdf_req = 1'b0;
    logic [1:0]   t3_kdf_slot = 2'd0;
    logic         t3_kdf_ack;
    logic [31:0]  t3_kdf_data;
    logic         t3_kdf_err;
    logic         t3_zeroize = 1'b0;
    logic         t3_busy;
    logic [2:0]   t3_slot_valid;
    logic [2:0]   t3_reads_exhausted;

    always #5 clock = ~clock;

    ttc3_secret_vault dut (
        .clock(clock), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_slot(wr_slot), .wr_data(wr_data),
        .wr_err(wr_err), .kdf_req(kdf_req), .kdf_slot(kdf_slot), .kdf_ack(kdf_ack),
        .kdf_data(kdf_data), .kdf_err(kdf_err), .zeroize(zeroize), .busy(busy),
`ifdef TTC3_VAULT_READ_LIMIT_EN
        .reads_exhausted(reads_exhausted),
`endif
        .slot_valid(slot_valid)
    );

    ttc3_secret_vault #(.NUM_SLOTS(3), .SECRET_WIDTH(32), .CHUNK_WIDTH(32)) dut3 (
        .clock(clock), .reset_n(reset_n),
        .wr_valid(t3_wr_valid), .wr_ready(t3_wr_ready), .wr_slot(t3_wr_slot),
        .wr_data(t3_wr_data), .wr_err(t3_wr_err), .kdf_req(t3_kdf_req),
        .kdf_slot(t3_kdf_slot), .kdf_ack(t3_kdf_ack), .kdf_data(t3_kdf_data),
        .kdf_err(t3_kdf_err), .zeroize(t3_zeroize), .busy(t3_busy),
`ifdef TTC3_VAULT_READ_LIMIT_EN
        .reads_exhausted(t3_reads_exhausted),
`endif
        .slot_valid(t3_slot_valid)
    );

`ifndef TTC3_VAULT_READ_LIMIT_EN
    assign reads_exhausted    = 4'd0;
    assign t3_reads_exhausted = 3'd0;
`endif

    typedef struct packed {
        logic         err;
        logic [255:0] data;
    } resp_t;

    resp_t        sb_q [$];
    resp_t        mon_exp;
    int           checks = 0;
    int           errors = 0;
    logic [255:0] m_secret [4];
    bit           m_valid [4];
    int           m_reads [4];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            m_secret[k] = '0;
            m_valid[k]  = 1'b0;
            m_reads[k]  = 0;
        end
    endtask

    task automatic model_load(input int s, input logic [31:0] base);
        m_valid[s] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m_secret[s][32*i +: 32] = base + 32'(i);
        end
    endtask

    function automatic resp_t model_read(input int s);
        resp_t r;
        r.err  = 1'b1;
        r.data = '0;
        if (s < 4) begin
            if (m_valid[s] && (!LIMIT_EN || m_reads[s] < 1)) begin
                r.err  = 1'b0;
                r.data = m_secret[s];
                m_reads[s]++;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] model_valid_vec();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = m_valid[k];
        return v;
    endfunction

    function automatic logic [3:0] model_exh_vec();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = LIMIT_EN && (m_reads[k] >= 1);
        return v;
    endfunction

    // Scoreboard monitor: every response pops an expectation; otherwise data must be zero.
    always @(negedge clock) begin
        if (reset_n) begin
            if (kdf_ack || kdf_err) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_resp", 256'(1'b1), 256'(1'b0));
                end else begin
                    mon_exp = sb_q.pop_front();
                    chk("sb_err", 256'(kdf_err), 256'(mon_exp.err));
                    chk("sb_ack", 256'(kdf_ack), 256'(!mon_exp.err));
                    chk("sb_data", kdf_data, mon_exp.data);
                end
            end else begin
                chk("data_zero_no_ack", kdf_data, 256'(0));
            end
        end
    end

    task automatic write_beats(input int s, input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_slot  = 2'(s);
            wr_data  = base + 32'(i);
            chk("wr_ready", 256'(wr_ready), 256'(1'b1));
            @(posedge clock); #1;
        end
        wr_valid = 1'b0;
    endtask

    task automatic kdf_read(input int s, output int lat);
        @(posedge clock); #1;
        sb_q.push_back(model_read(s));
        kdf_req  = 1'b1;
        kdf_slot = 2'(s);
        lat      = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock); #1;
            if (kdf_ack || kdf_err) begin
                lat = i;
                break;
            end
        end
        kdf_req = 1'b0;
        if (lat == 0) begin
            chk("kdf_timeout", 256'(1'b0), 256'(1'b1));
            sb_q.delete();
        end
    endtask

    task automatic kdf3_read(input int s, input logic exp_err, input logic [31:0] exp_data);
        @(posedge clock); #1;
        t3_kdf_req  = 1'b1;
        t3_kdf_slot = 2'(s);
        @(posedge clock); #1;
        chk("t3_kdf_ack", 256'(t3_kdf_ack), 256'(!exp_err));
        chk("t3_kdf_err", 256'(t3_kdf_err), 256'(exp_err));
        chk("t3_kdf_data", 256'(t3_kdf_data), 256'(exp_data));
        t3_kdf_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int lat;
        int bc;
        model_clear();

        // Reset values
        repeat (3) @(posedge clock);
        #1;
        chk("rst_wr_ready", 256'(wr_ready), 256'(1'b0));
        chk("rst_busy", 256'(busy), 256'(1'b0));
        chk("rst_slot_valid", 256'(slot_valid), 256'(4'b0000));
        chk("rst_resp", 256'({wr_err, kdf_ack, kdf_err}), 256'(3'b000));
        chk("rst_kdf_data", kdf_data, 256'(0));
        reset_n = 1'b1;
        @(posedge clock); #1;
        chk("rel_wr_ready", 256'(wr_ready), 256'(1'b1));

        // T1: load slot 2 with 0..7, valid only after the last beat, read back
        write_beats(2, 32'h0, 7);
        chk("t1_valid_partial", 256'(slot_valid), 256'(4'b0000));
        chk("t1_busy_load", 256'(busy), 256'(1'b1));
        write_beats(2, 32'h7, 1);
        model_load(2, 32'h0);
        chk("t1_valid", 256'(slot_valid), 256'(4'b0100));
        chk("t1_busy_idle", 256'(busy), 256'(1'b0));
        kdf_read(2, lat);
        chk("t1_latency", 256'(lat), 256'(1));

        // T2: rewrite of a locked slot is rejected
        wr_valid = 1'b1; wr_slot = 2'd2; wr_data = 32'h11111111;
        @(posedge clock); #1;
        wr_valid = 1'b0;
        chk("t2_wr_err", 256'(wr_err), 256'(1'b1));
        chk("t2_busy", 256'(busy), 256'(1'b0));
        @(posedge clock); #1;
        chk("t2_wr_err_pulse", 256'(wr_err), 256'(1'b0));
        kdf_read(2, lat);
        chk("t2_latency", 256'(lat), 256'(1));

        // T3: empty slot reads
        kdf_read(1, lat);
        kdf_read(3, lat);

        // T4: partial load then zeroize, reload
        write_beats(0, 32'hA0, 4);
        chk("t4_busy_load", 256'(busy), 256'(1'b1));
        zeroize = 1'b1;
        @(posedge clock); #1;
        zeroize = 1'b0;
        chk("t4_wr_ready_zero", 256'(wr_ready), 256'(1'b0));
        bc = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy) bc++;
            @(posedge clock); #1;
        end
        model_clear();
        chk("t4_busy_cycles", 256'(bc), 256'(4));
        chk("t4_valid_cleared", 256'(slot_valid), 256'(4'b0000));
        kdf_read(2, lat);
        write_beats(0, 32'hB0, 8);
        model_load(0, 32'hB0);
        chk("t4_valid_reload", 256'(slot_valid), 256'(model_valid_vec()));
        kdf_read(0, lat);
        kdf_read(0, lat);
        chk("t4_exhausted", 256'(reads_exhausted), 256'(model_exh_vec()));

        // T5: request held off by a LOAD, then zeroize beats a same-cycle request
        write_beats(2, 32'h200, 8);
        model_load(2, 32'h200);
        write_beats(3, 32'h300, 1);
        sb_q.push_back(model_read(2));
        kdf_req = 1'b1; kdf_slot = 2'd2;
        for (int i = 1; i < 8; i++) begin
            wr_valid = 1'b1; wr_slot = 2'd1; wr_data = 32'h300 + 32'(i);
            @(posedge clock); #1;
            chk("t5_no_resp_in_load", 256'({kdf_ack, kdf_err}), 256'(2'b00));
        end
        wr_valid = 1'b0;
        model_load(3, 32'h300);
        chk("t5_valid", 256'(slot_valid), 256'(model_valid_vec()));
        chk("t5_busy_idle", 256'(busy), 256'(1'b0));
        @(posedge clock); #1;
        chk("t5_ack_after_load", 256'(kdf_ack), 256'(1'b1));
        kdf_req = 1'b0;
        @(posedge clock); #1;
        zeroize = 1'b1; kdf_req = 1'b1; kdf_slot = 2'd3;
        @(posedge clock); #1;
        zeroize = 1'b0; kdf_req = 1'b0;
        chk("t5_zero_no_resp", 256'({kdf_ack, kdf_err}), 256'(2'b00));
        chk("t5_zero_busy", 256'(busy), 256'(1'b1));
        for (int i = 0; i < 20 && busy; i++) begin
            @(posedge clock); #1;
        end
        model_clear();
        chk("t5_zero_done", 256'({busy, slot_valid}), 256'(5'b00000));

        // T6: asynchronous reset mid-LOAD
        write_beats(1, 32'h100, 3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_busy", 256'(busy), 256'(1'b0));
        chk("t6_wr_ready", 256'(wr_ready), 256'(1'b0));
        chk("t6_slot_valid", 256'(slot_valid), 256'(4'b0000));
        chk("t6_kdf_data", kdf_data, 256'(0));
        model_clear();
        @(posedge clock); #3;
        reset_n = 1'b1;
        @(posedge clock); #1;
        chk("t6_exhausted", 256'(reads_exhausted), 256'(4'b0000));
        kdf_read(1, lat);

        // Three-slot, single-beat vault: out-of-range index and immediate commit
        t3_wr_valid = 1'b1; t3_wr_slot = 2'd3; t3_wr_data = 32'hDEAD0003;
        @(posedge clock); #1;
        t3_wr_valid = 1'b0;
        chk("t3_wr_err_range", 256'(t3_wr_err), 256'(1'b1));
        chk("t3_valid_none", 256'(t3_slot_valid), 256'(3'b000));
        t3_wr_valid = 1'b1; t3_wr_slot = 2'd1; t3_wr_data = 32'hCAFE0001;
        @(posedge clock); #1;
        t3_wr_valid = 1'b0;
        chk("t3_commit", 256'({t3_busy, t3_wr_err, t3_slot_valid}), 256'(5'b00010));
        kdf3_read(3, 1'b1, 32'h0);
        kdf3_read(1, 1'b0, 32'hCAFE0001);
        chk("t3_exhausted", 256'(t3_reads_exhausted), 256'(LIMIT_EN ? 3'b010 : 3'b000));
        t3_zeroize = 1'b1;
        @(posedge clock); #1;
        t3_zeroize = 1'b0;
        bc = 0;
        for (int i = 0; i < 8; i++) begin
            if (t3_busy) bc++;
            @(posedge clock); #1;
        end
        chk("t3_zero_cycles", 256'(bc), 256'(3));
        chk("t3_zero_valid", 256'(t3_slot_valid), 256'(3'b000));

        @(posedge clock); #1;
        chk("sb_drain", 256'(sb_q.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ttc3_secret_vault.md
Name: ttc3_secret_vault

Overview:
Multi-slot successor to the single-secret DUS store. It holds NUM_SLOTS device secrets, each write-once and loaded in CHUNK_WIDTH beats over a valid/ready bus. Secrets are released to the KDF only through a request/acknowledge handshake with a slot select. A zeroize command wipes all slots through a sequenced FSM. It sits between the provisioning/fuse-shadow path and the KDF in the TTC3 root-of-trust.

Parameters:
NUM_SLOTS, 4, number of secret slots (1..16)
SECRET_WIDTH, 256, bits per secret; must be an integer multiple of CHUNK_WIDTH
CHUNK_WIDTH, 32, write beat width
SLOT_W (localparam), max(1,$clog2(NUM_SLOTS)), slot index width
NUM_CHUNKS (localparam), SECRET_WIDTH/CHUNK_WIDTH, beats per secret

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
wr_valid  in  1  write beat valid
wr_ready  out  1  write beat accepted when valid&ready
wr_slot  in  SLOT_W  target slot, sampled on the first beat only
wr_data  in  CHUNK_WIDTH  beat data, LSB chunk first
wr_err  out  1  1-cycle pulse: write rejected
kdf_req  in  1  level KDF read request
kdf_slot  in  SLOT_W  slot to read, sampled when the request is taken
kdf_ack  out  1  1-cycle pulse: kdf_data valid
kdf_data  out  SECRET_WIDTH  secret; all-zero except in the kdf_ack cycle
kdf_err  out  1  1-cycle pulse: read of an invalid or out-of-range slot
zeroize  in  1  wipe request, sampled each cycle
busy  out  1  high in LOAD or ZEROIZE
slot_valid  out  NUM_SLOTS  per-slot secret-present flags

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, all slot storage=0, slot_valid=0, chunk counter=0, wr_ready=0, wr_err=0, kdf_ack=0, kdf_err=0, kdf_data=0, busy=0.
- FSM states: IDLE, LOAD, ZEROIZE. Zeroize has the highest priority from any state, then write, then KDF.
- wr_ready = 1 in IDLE and LOAD, and 0 in ZEROIZE or in any cycle where zeroize=1. It is combinational from state and zeroize.
- IDLE, write beat accepted:
  - If wr_slot >= NUM_SLOTS or slot_valid[wr_slot]=1: the beat is consumed, wr_err pulses next cycle, and no state changes (write-once lock).
  - Otherwise: latch the slot, store the beat in chunk 0, set counter=1, go to LOAD. If NUM_CHUNKS=1, commit immediately instead.
- LOAD:
  - Each accepted beat fills chunk[counter] and increments the counter. wr_slot is ignored.
  - On the final beat (counter=NUM_CHUNKS-1), slot_valid[slot] is set on the same clock edge that stores the beat. It is visible the next cycle. Return to IDLE.
  - Idle cycles (wr_valid=0) are allowed without limit.
- KDF:
  - A request is taken only in IDLE, when no write beat is accepted that cycle, and when kdf_ack/kdf_err was not asserted the previous cycle.
  - The cycle after a taken request, exactly one of these occurs: kdf_ack=1 with kdf_data=secret[kdf_slot], or kdf_err=1 with kdf_data=0.
  - Latency is 1 cycle. In LOAD or ZEROIZE the request stays pending until IDLE.
  - The requester drops kdf_req in the cycle after the response; a request still high one cycle later is a new request.
- Zeroize:
  - zeroize=1 in any state: discard any partial LOAD (the partial chunks are cleared, not committed). Any pending response cycle is still suppressed, so kdf_data=0.
  - Enter ZEROIZE. Clear slot k (data and valid bit) on the k-th cycle, k=0..NUM_SLOTS-1, then return to IDLE.
  - busy=1 throughout. Total ZEROIZE duration = NUM_SLOTS cycles.
  - zeroize asserted again during ZEROIZE restarts the sequence at slot 0.
- Secret bits never reach kdf_data except in an ack cycle. There is no other read path.

Optional Feature:
TTC3_VAULT_READ_LIMIT_EN:
- Defined:
  - Adds parameter READ_LIMIT (default 1) and a per-slot saturating read counter, cleared by reset or zeroize of that slot.
  - A KDF read of a slot whose count has reached READ_LIMIT returns kdf_err and zero data.
  - Adds output reads_exhausted [NUM_SLOTS].
- Undefined: unlimited reads; no counters; no reads_exhausted port.

Test Plan:
1. Reset, then load slot 2 with 8 beats 0x00000000..0x00000007 (LSB first) -> slot_valid=4'b0100 one cycle after the 8th beat; KDF read of slot 2 -> kdf_ack after 1 cycle with kdf_data=256'h00000007_00000006_..._00000000.
2. Rewrite slot 2 with 0x11111111 beats -> wr_err pulses on the first beat, FSM stays IDLE, slot 2 data unchanged on re-read.
3. KDF read of slot 1 (empty) and of slot index 3 with NUM_SLOTS=3 -> kdf_err pulse; kdf_data=0 in every non-ack cycle, including while kdf_req=0.
4. Load slot 0 with 4 of 8 beats, then pulse zeroize -> busy=1 for exactly 4 cycles, slot_valid=0; load slot 0 again with 8 beats -> succeeds, read returns only the new data.
5. Assert kdf_req (slot 2) during a LOAD of slot 3 -> no response until LOAD completes; kdf_ack arrives 1 cycle after return to IDLE; zeroize and kdf_req in the same cycle -> no ack, ZEROIZE entered.
6. Drop reset_n asynchronously mid-LOAD between clock edges -> all outputs go to their reset values immediately; with TTC3_VAULT_READ_LIMIT_EN and READ_LIMIT=1, a second read of a loaded slot -> kdf_err and reads_exhausted bit set.
